mdu_hilo_producer: RTL
======================

Name: mdu_hilo_producer

Overview:
- Iterative multiply/divide unit: the producer side of the register file's HI/LO write interface.
- Accepts MULT/MULTU/DIV/DIVU operands from the decode stage (rs/rt data) and computes over 32 cycles.
- Issues one combined HI+LO write to the register file per operation: write_data=LO, write_data_hi=HI, HiLotype=3'b011, one-cycle write enable.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; latched with start.
- flush  in  1  synchronous cancel of the in-flight operation.
- rs_data  in  WIDTH  multiplicand / dividend.
- rt_data  in  WIDTH  multiplier / divisor.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- hilo_we  out  1  register-file reg_write for HI/LO; equals done.
- hilo_type  out  3  3'b011 while done, else 3'b000.
- lo_out  out  WIDTH  product low word / quotient; drives write_data.
- hi_out  out  WIDTH  product high word / remainder; drives write_data_hi.
- div_by_zero  out  1  set with done when a DIV/DIVU had rt=0.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy, done, hilo_we, div_by_zero=0; hilo_type=3'b000; lo_out, hi_out=0; counter=0.
- States:
  - IDLE -> CALC: on start & !flush. At that edge E0, capture op and abs values of operands (signed ops only), capture sign flags, and set counter=0.
  - CALC: one radix-2 step per edge; counter increments. After the step at counter==WIDTH-1 (edge E32), go to FIX.
  - FIX: at edge E33, apply sign correction, register hi_out/lo_out/div_by_zero, pulse done/hilo_we/hilo_type for exactly one cycle, return to IDLE.
- Latency: done is high during the cycle after edge E33, i.e. 33 edges after the start edge. Rate is one op per 34 cycles.
- busy is 1 in CALC and FIX, and 0 in the done cycle. start during the done cycle is accepted.
- start while busy is ignored: no queueing, no effect on the in-flight op.
- Multiply: unsigned shift-add on the 2*WIDTH accumulator {hi,lo}. Signed: negate the 64-bit product when the operand signs differ (two's complement, 64-bit wrap).
- Divide: restoring, one quotient bit per cycle.
  - Signed: quotient negated when the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 with no trap.
- Divide by zero: full latency; LO=all-ones, HI=rs_data (unsigned dividend, unmodified, for both DIV and DIVU); div_by_zero=1. div_by_zero clears on the next done.
- hi_out/lo_out hold their values between done pulses. They update only at a done edge.
- flush:
  - In CALC or FIX: return to IDLE next edge, busy=0, no done, outputs unchanged.
  - flush & start in IDLE: flush wins, start is dropped.
  - Flush in the same cycle as done: done is already registered and is not retracted.
- reset_n asserted mid-operation: immediate return to reset values; no done, no HI/LO write.
- All arithmetic is WIDTH-bit or 2*WIDTH-bit unsigned internally; no X propagation from unselected ops.

Decomposition:
- Package mdu_pkg:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum: IDLE, CALC, FIX.
  - HiLotype constants: HILO_NONE=3'b000, HILO_BOTH=3'b011, plus the register file's HI-only, LO-only and GPR codes, so both ends share one definition.
- Control FSM and datapath stay in one module.
- One natural sub-module, mdu_sign_fix: combinational abs-on-entry and negate-on-exit for the signed variants, reused at E0 and at FIX.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done 33 edges after start; HI=0xFFFFFFFE, LO=0x00000001; hilo_type=3'b011 for one cycle.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=0x00000064, div_by_zero=1.
- DIVU 100/7 started with a second start pulse at cycle 5 -> single done with LO=14, HI=2; the second start is ignored.
- Flush and reset mid-operation:
  - Flush at cycle 10 of a MULTU 3*5 -> busy=0 next edge, no done, HI/LO keep previous values.
  - reset_n low at cycle 20 of a MULTU 3*5 -> all outputs 0 immediately, no done.
  - After either, restarting MULTU 3*5 -> LO=15, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and its HI/LO consumer.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [2:0] HILO_NONE = 3'b000;
  localparam logic [2:0] HILO_HI   = 3'b001;
  localparam logic [2:0] HILO_LO   = 3'b010;
  localparam logic [2:0] HILO_BOTH = 3'b011;
  localparam logic [2:0] HILO_GPR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic logic op_is_div(
    input logic [1:0] op
  );
    return op[1];
  endfunction

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Abs-on-entry and negate-on-exit for the signed MDU variants.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               sgn_i,
  input  logic [WIDTH-1:0]   rs_i,
  input  logic [WIDTH-1:0]   rt_i,
  output logic [WIDTH-1:0]   abs_rs_o,
  output logic [WIDTH-1:0]   abs_rt_o,
  output logic               rs_neg_o,
  output logic               rt_neg_o,
  input  logic               res_div_i,
  input  logic               res_rs_neg_i,
  input  logic               res_rt_neg_i,
  input  logic [2*WIDTH-1:0] res_acc_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               neg;

  assign rs_neg_o = sgn_i & rs_i[WIDTH-1];
  assign rt_neg_o = sgn_i & rt_i[WIDTH-1];
  assign abs_rs_o = rs_neg_o ? (~rs_i + 1'b1) : rs_i;
  assign abs_rt_o = rt_neg_o ? (~rt_i + 1'b1) : rt_i;

  assign neg  = res_rs_neg_i ^ res_rt_neg_i;
  assign prod = neg ? (~res_acc_i + 1'b1) : res_acc_i;
  assign quo  = neg ? (~res_acc_i[WIDTH-1:0] + 1'b1)
                    : res_acc_i[WIDTH-1:0];
  // Remainder follows the dividend's sign.
  assign rem  = res_rs_neg_i
              ? (~res_acc_i[2*WIDTH-1:WIDTH] + 1'b1)
              : res_acc_i[2*WIDTH-1:WIDTH];

  assign hi_o = res_div_i ? rem : prod[2*WIDTH-1:WIDTH];
  assign lo_o = res_div_i ? quo : prod[WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo_producer.sv
// Iterative MULT/DIV unit driving one combined HI+LO register write.
module mdu_hilo_producer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [2:0]       hilo_type,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int W2    = 2 * WIDTH;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q;
  logic [W2-1:0]      acc_q;
  logic [W2-1:0]      acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   rs_raw_q;
  logic               rsn_q;
  logic               rtn_q;
  logic               dbz_pend_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH+1:0]   diff;
  logic               unused_diff;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .sgn_i        (op_is_signed(op)),
    .rs_i         (rs_data),
    .rt_i         (rt_data),
    .abs_rs_o     (abs_rs),
    .abs_rt_o     (abs_rt),
    .rs_neg_o     (rs_neg),
    .rt_neg_o     (rt_neg),
    .res_div_i    (div_q),
    .res_rs_neg_i (rsn_q),
    .res_rt_neg_i (rtn_q),
    .res_acc_i    (acc_q),
    .hi_o         (fix_hi),
    .lo_o         (fix_lo)
  );

  assign add_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opb_q};
  assign trial   = acc_q[W2-1:WIDTH-1];
  assign diff    = {1'b0, trial} - {2'b00, opb_q};
  // Top diff bit only matters for rt=0, whose result is overridden.
  assign unused_diff = diff[WIDTH];

  always_comb begin
    acc_d = acc_q;
    if (div_q) begin
      if (!diff[WIDTH+1])
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_d = {acc_q[W2-2:0], 1'b0};
    end else begin
      if (acc_q[0])
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      else
        acc_d = {1'b0, acc_q[W2-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      acc_q      <= '0;
      opb_q      <= '0;
      rs_raw_q   <= '0;
      rsn_q      <= 1'b0;
      rtn_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !flush) begin
            state_q    <= CALC;
            cnt_q      <= '0;
            div_q      <= op_is_div(op);
            acc_q      <= {{WIDTH{1'b0}}, abs_rs};
            opb_q      <= abs_rt;
            rs_raw_q   <= rs_data;
            rsn_q      <= rs_neg;
            rtn_q      <= rt_neg;
            dbz_pend_q <= op_is_div(op) && (rt_data == '0);
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1))
              state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush) begin
            done_q <= 1'b1;
            dbz_q  <= dbz_pend_q;
            if (dbz_pend_q) begin
              lo_q <= '1;
              hi_q <= rs_raw_q;
            end else begin
              lo_q <= fix_lo;
              hi_q <= fix_hi;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hilo_we     = done_q;
  assign hilo_type   = done_q ? HILO_BOTH : HILO_NONE;
  assign lo_out      = lo_q;
  assign hi_out      = hi_q;
  assign div_by_zero = dbz_q;

endmodule
